// File: rtl/program_loader.sv
// Byte-stream boot loader: assembles a framed little-endian program image into
// 32-bit instruction-memory writes and holds the core in reset until a good load.
module program_loader #(
    parameter int          MEMORY_DEPTH = 512,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  ImemWrite,
    output logic [31:0]           ImemAddress,
    output logic [DATA_WIDTH-1:0] ImemData,
    output logic                  CoreReset,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [15:0] MAX_WORDS = 16'(MEMORY_DEPTH);

    state_t                  state_q, state_d;
    logic [15:0]             idx_q, idx_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [7:0]              sum_q, sum_d;
    logic [15:0]             len_q, len_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [31:0]             addr_q, addr_d;
    logic                    ready_q, ready_d;
    logic                    write_q, write_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    core_rst_q, core_rst_d;

    logic                    xfer;
    logic [15:0]             len_full;
    logic [15:0]             idx_next;

    assign xfer     = ByteValid && ready_q;
    assign len_full = {ByteIn, len_q[7:0]};
    assign idx_next = idx_q + 16'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        len_d   = len_q;
        data_d  = data_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN_LO;
                    idx_d   = '0;
                    cnt_d   = '0;
                    sum_d   = '0;
                    data_d  = '0;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = ByteIn;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = ByteIn;
                    if (len_full > MAX_WORDS)
                        state_d = S_ERROR;
                    else if (len_full == 16'd0)
                        state_d = S_CHECK;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    data_d[{cnt_q, 3'b000} +: 8] = ByteIn;
                    sum_d = sum_q + ByteIn;
                    cnt_d = cnt_q + 2'd1;
                    // Address is captured on the way into WRITE so it is stable for the strobe.
                    if (cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        addr_d  = BASE_ADDRESS + {14'd0, idx_q, 2'b00};
                    end
                end
            end
            S_WRITE: begin
                idx_d   = idx_next;
                state_d = (idx_next == len_q) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                if (xfer)
                    state_d = (ByteIn == sum_q) ? S_DONE : S_ERROR;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight from flops.
        ready_d    = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                     (state_d == S_DATA)   || (state_d == S_CHECK);
        write_d    = (state_d == S_WRITE);
        busy_d     = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERROR);
        core_rst_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            len_q      <= '0;
            data_q     <= '0;
            addr_q     <= BASE_ADDRESS;
            ready_q    <= 1'b0;
            write_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            len_q      <= len_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            ready_q    <= ready_d;
            write_q    <= write_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            core_rst_q <= core_rst_d;
        end
    end

    assign ByteReady   = ready_q;
    assign ImemWrite   = write_q;
    assign ImemAddress = addr_q;
    assign ImemData    = data_q;
    assign CoreReset   = core_rst_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Error       = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framed loads, bad checksum, overflow,
// empty image, stream gaps with a stray start, and reset during a load.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        ImemWrite;
    logic [31:0] ImemAddress;
    logic [31:0] ImemData;
    logic        CoreReset;
    logic        Busy;
    logic        Done;
    logic        Error;

    program_loader #(
        .MEMORY_DEPTH(512),
        .DATA_WIDTH  (32),
        .BASE_ADDRESS(32'h0040_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ByteIn     (ByteIn),
        .ByteValid  (ByteValid),
        .ByteReady  (ByteReady),
        .ImemWrite  (ImemWrite),
        .ImemAddress(ImemAddress),
        .ImemData   (ImemData),
        .CoreReset  (CoreReset),
        .Busy       (Busy),
        .Done       (Done),
        .Error      (Error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write monitor: log every strobe, flag ready-during-write and back-to-back strobes.
    int          wr_cnt    = 0;
    int          rdy_in_wr = 0;
    int          dbl_wr    = 0;
    logic        prev_wr   = 1'b0;
    logic [31:0] wr_addr[32];
    logic [31:0] wr_data[32];

    always @(negedge clk) begin
        if (ImemWrite === 1'b1) begin
            if (wr_cnt < 32) begin
                wr_addr[wr_cnt] = ImemAddress;
                wr_data[wr_cnt] = ImemData;
            end
            wr_cnt++;
            if (ByteReady !== 1'b0) rdy_in_wr++;
            if (prev_wr) dbl_wr++;
        end
        prev_wr = (ImemWrite === 1'b1);
    end

    logic [7:0] good[11];

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        acc = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            ByteValid = 1'b0;
        end
        @(negedge clk);
        ByteIn    = b;
        ByteValid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            acc = ByteReady;
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
        end
        #1 ByteValid = 1'b0;
        if (!acc) chk("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_seq(input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++)
            send_byte(good[i], gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_two_writes(input string tag, input int base);
        chk({tag, "_wcount"}, 32'(wr_cnt - base), 32'd2);
        chk({tag, "_addr0"}, wr_addr[base], 32'h0040_0000);
        chk({tag, "_data0"}, wr_data[base], 32'h1234_5678);
        chk({tag, "_addr1"}, wr_addr[base + 1], 32'h0040_0004);
        chk({tag, "_data1"}, wr_data[base + 1], 32'hDEAD_BEEF);
    endtask

    initial begin
        int base;
        good = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
        reset     = 1'b1;
        start     = 1'b0;
        ByteIn    = 8'h00;
        ByteValid = 1'b0;
        #1;
        chk("rst_corereset", 32'(CoreReset), 32'd1);
        chk("rst_busy",      32'(Busy),      32'd0);
        chk("rst_done",      32'(Done),      32'd0);
        chk("rst_error",     32'(Error),     32'd0);
        chk("rst_ready",     32'(ByteReady), 32'd0);
        chk("rst_write",     32'(ImemWrite), 32'd0);
        chk("rst_addr",      ImemAddress,    32'h0040_0000);
        chk("rst_data",      ImemData,       32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Good load
        base = wr_cnt;
        pulse_start();
        chk("good_ready_lenlo", 32'(ByteReady), 32'd1);
        chk("good_busy",        32'(Busy),      32'd1);
        send_seq(0, 10, 1'b0);
        @(negedge clk);
        check_two_writes("good", base);
        chk("good_done",      32'(Done),      32'd1);
        chk("good_corereset", 32'(CoreReset), 32'd0);
        chk("good_busy_end",  32'(Busy),      32'd0);

        // Bad checksum
        base = wr_cnt;
        pulse_start();
        chk("bad_corereset_start", 32'(CoreReset), 32'd1);
        send_seq(0, 9, 1'b0);
        send_byte(8'h4D, 0);
        @(negedge clk);
        check_two_writes("bad", base);
        chk("bad_error",     32'(Error),     32'd1);
        chk("bad_done",      32'(Done),      32'd0);
        chk("bad_corereset", 32'(CoreReset), 32'd1);

        // Length overflow (N = 513)
        base = wr_cnt;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        @(negedge clk);
        chk("ovf_error",  32'(Error),            32'd1);
        chk("ovf_ready",  32'(ByteReady),        32'd0);
        chk("ovf_busy",   32'(Busy),             32'd0);
        chk("ovf_writes", 32'(wr_cnt - base),    32'd0);

        // Empty image
        base = wr_cnt;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        chk("empty_done",      32'(Done),         32'd1);
        chk("empty_corereset", 32'(CoreReset),    32'd0);
        chk("empty_writes",    32'(wr_cnt - base), 32'd0);
        pulse_start();
        chk("restart_corereset", 32'(CoreReset), 32'd1);
        chk("restart_busy",      32'(Busy),      32'd1);

        // Gapped stream with a stray start during DATA (loader already in LEN_LO)
        base = wr_cnt;
        pulse_start();
        chk("gap_ready_lenlo", 32'(ByteReady), 32'd1);
        send_seq(0, 3, 1'b1);
        pulse_start();
        chk("gap_busy_mid", 32'(Busy), 32'd1);
        send_seq(4, 10, 1'b1);
        @(negedge clk);
        check_two_writes("gap", base);
        chk("gap_done", 32'(Done), 32'd1);

        // Reset during the first word
        base = wr_cnt;
        pulse_start();
        send_seq(0, 3, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_corereset", 32'(CoreReset), 32'd1);
        chk("mid_write",     32'(ImemWrite), 32'd0);
        chk("mid_busy",      32'(Busy),      32'd0);
        chk("mid_ready",     32'(ByteReady), 32'd0);
        chk("mid_data",      ImemData,       32'h0);
        chk("mid_addr",      ImemAddress,    32'h0040_0000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_idle_busy", 32'(Busy), 32'd0);
        pulse_start();
        send_seq(0, 10, 1'b0);
        @(negedge clk);
        check_two_writes("mid_reload", base);
        chk("mid_reload_done", 32'(Done), 32'd1);

        chk("ready_during_write", 32'(rdy_in_wr), 32'd0);
        chk("write_multi_cycle",  32'(dbl_wr),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
